button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
- Front-end stage that conditions the raw board push-buttons before they reach the game logic.
- Each button is synchronised into the pixel clock domain and debounced.
- Each button produces a stable level, a one-cycle press pulse and a one-cycle release pulse.
- The game logic uses the press pulse of the centre button for regime toggling (one toggle per physical press) and the levels of the direction buttons for board movement.

Parameters:
- NUM_BUTTONS, 5, number of independent button channels. Bit map: 0=c, 1=u, 2=d, 3=r, 4=l.
- DEBOUNCE_CYCLES, 360000, consecutive stable synchronised cycles required to accept a new level (10 ms at 36 MHz). Legal range is 1 or more.
- SYNC_STAGES, 2, flip-flop depth of the input synchroniser. Legal range is 2 or more.

Ports:
- pixel_clk  input  1  single clock, 36 MHz pixel clock.
- rst_n  input  1  reset, asynchronous assert, active-low.
- btn_raw  input  NUM_BUTTONS  raw asynchronous button inputs, active-high.
- btn_level  output  NUM_BUTTONS  debounced button state, 1 = held.
- btn_press  output  NUM_BUTTONS  one-cycle pulse on each accepted 0->1 transition of btn_level.
- btn_release  output  NUM_BUTTONS  one-cycle pulse on each accepted 1->0 transition of btn_level.

Behaviour:
- Clock and reset: one clock, pixel_clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - All synchroniser flops are 0.
  - All channel FSMs are in IDLE with counters at 0.
  - btn_level, btn_press and btn_release are all 0.
- Reset mid-debounce discards all progress. After release, the first press needs the full latency again.
- Channels are fully independent. There is no cross-channel priority, and simultaneous presses are each reported in their own bit on the same cycle.
- Synchroniser: a chain of SYNC_STAGES flops per bit; the last stage is the signal s. Metastability protection only; no filtering.
- Per-channel FSM with 4 states and counter cnt, width CNT_W = max(1, clog2(DEBOUNCE_CYCLES)):
  - IDLE (level 0):
    - s=1: go to WAIT_PRESS, cnt<=0.
  - WAIT_PRESS (level 0):
    - s=0: go to IDLE (bounce rejected, no pulse).
    - s=1 and cnt==DEBOUNCE_CYCLES-1: go to PRESSED, level<=1, press<=1.
    - otherwise: cnt<=cnt+1.
  - PRESSED (level 1):
    - s=0: go to WAIT_RELEASE, cnt<=0.
  - WAIT_RELEASE (level 1):
    - s=1: go to PRESSED (glitch rejected, no pulse).
    - s=0 and cnt==DEBOUNCE_CYCLES-1: go to IDLE, level<=0, release<=1.
    - otherwise: cnt<=cnt+1.
- Pulses are high for exactly one cycle, the same cycle btn_level first shows its new value. Outputs are all registered; there is no combinational path from btn_raw.
- Latency: with btn_raw first sampled high at edge 1 and held, btn_level and btn_press go high after edge SYNC_STAGES+1+DEBOUNCE_CYCLES. Release is symmetric.
- Boundary conditions:
  - A glitch of fewer than DEBOUNCE_CYCLES synchronised cycles never changes btn_level.
  - The counter never wraps; it is reloaded on every bounce.
  - A continuously held button gives exactly one press pulse, with no auto-repeat.
  - Press and release pulses are never high together on the same bit.
  - Press pulses on a bit are always separated by at least 2*DEBOUNCE_CYCLES+2 cycles.

Decomposition:
- Shared package btn_pkg holds:
  - typedef enum logic [1:0] btn_state_t {IDLE, WAIT_PRESS, PRESSED, WAIT_RELEASE};
  - localparams BTN_C=0, BTN_U=1, BTN_D=2, BTN_R=3, BTN_L=4.
- One natural sub-module, btn_debounce_ch: synchroniser, FSM and counter for one bit. Parameters DEBOUNCE_CYCLES and SYNC_STAGES.
- button_conditioner is a generate loop of NUM_BUTTONS instances of btn_debounce_ch.

Test Plan (DEBOUNCE_CYCLES=4, SYNC_STAGES=2, times in pixel_clk edges):
- Clean press: btn_raw[0] goes 0->1 before edge 1 and is held -> btn_level[0] and btn_press[0] go 1 after edge 7; btn_press[0] is 0 again after edge 8; btn_level[0] stays 1.
- Bounce rejection: btn_raw[1] pattern 1,1,0,1,1,0 on successive edges, then 0 -> btn_level[1] stays 0 and btn_press[1] never pulses.
- Release with glitch: hold btn_raw[2] until btn_level[2]=1, drop to 0 for 2 cycles, back to 1 for 3 cycles, then drop to 0 and hold -> no release pulse for the glitch; btn_release[2] pulses exactly once, 7 edges after the final drop.
- Simultaneous presses: btn_raw = 5'b10101 asserted on the same edge and held -> btn_press = 5'b10101 for exactly one cycle after edge 7; long hold of 1000 cycles gives no further pulses.
- Async reset mid-debounce: assert rst_n=0 between edges while channel 3 is in WAIT_PRESS -> all outputs 0 immediately, before the next edge. Release reset with btn_raw[3] held -> press pulse 7 edges after the first edge following deassertion.
- Regime toggle usage: two distinct 20-cycle presses on bit 0, separated by 20 idle cycles -> exactly two btn_press[0] pulses. Feeding them to the regime toggle gives regime 1 -> 0 -> 1.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared types and constants for the push-button front end.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_PRESS,
    PRESSED,
    WAIT_RELEASE
  } btn_state_t;

  localparam int BTN_C = 0;
  localparam int BTN_U = 1;
  localparam int BTN_D = 2;
  localparam int BTN_R = 3;
  localparam int BTN_L = 4;

  // Counter width for a debounce window; never narrower than one bit.
  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: input synchroniser, debounce FSM with a stability
// counter, and registered level / press / release outputs.
//
//   state        | meaning
//   -------------+-----------------------------------------------------
//   IDLE         | released and stable, level 0
//   WAIT_PRESS   | input seen high, counting stable-high cycles, level 0
//   PRESSED      | held and stable, level 1
//   WAIT_RELEASE | input seen low, counting stable-low cycles, level 1
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 360000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic pixel_clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  localparam int             CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  btn_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_d, press_d, release_d;

  // Shift the raw input through the metastability chain.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // State, counter and all outputs are registered together.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      btn_level   <= level_d;
      btn_press   <= press_d;
      btn_release <= release_d;
    end
  end

  // Next-state logic; pulses default low so they last exactly one cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = btn_level;
    press_d   = 1'b0;
    release_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        level_d = 1'b0;
        if (s) begin
          state_d = WAIT_PRESS;
          cnt_d   = '0;
        end
      end
      WAIT_PRESS: begin
        level_d = 1'b0;
        if (!s) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESSED: begin
        level_d = 1'b1;
        if (!s) begin
          state_d = WAIT_RELEASE;
          cnt_d   = '0;
        end
      end
      WAIT_RELEASE: begin
        level_d = 1'b1;
        if (s) begin
          state_d = PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/button_conditioner.sv
// Conditions the board push-buttons (bit map c,u,d,r,l) into the pixel
// clock domain; every channel is independent.
module button_conditioner
  import btn_pkg::*;
#(
  parameter int NUM_BUTTONS     = 5,
  parameter int DEBOUNCE_CYCLES = 360000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                   pixel_clk,
  input  logic                   rst_n,
  input  logic [NUM_BUTTONS-1:0] btn_raw,
  output logic [NUM_BUTTONS-1:0] btn_level,
  output logic [NUM_BUTTONS-1:0] btn_press,
  output logic [NUM_BUTTONS-1:0] btn_release
);

  // One debounce channel per button bit.
  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES)
    ) u_ch (
      .pixel_clk   (pixel_clk),
      .rst_n       (rst_n),
      .btn_raw     (btn_raw[i]),
      .btn_level   (btn_level[i]),
      .btn_press   (btn_press[i]),
      .btn_release (btn_release[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with a short debounce window. Stimulus pushes
// expected pulse events; the monitor pops and compares as pulses appear.
module tb_button_conditioner;

  localparam int NB  = 5;
  localparam int DC  = 4;
  localparam int SS  = 2;
  localparam int LAT = SS + 1 + DC;

  logic          pixel_clk;
  logic          rst_n;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_release;

  typedef struct {
    int cyc;
    int bitn;
    int is_press;
  } ev_t;

  ev_t exp_q[$];
  int  cyc;
  int  n_total;
  int  n_pass;
  int  regime;
  int  press0_cnt;

  button_conditioner #(
    .NUM_BUTTONS     (NB),
    .DEBOUNCE_CYCLES (DC),
    .SYNC_STAGES     (SS)
  ) dut (
    .pixel_clk   (pixel_clk),
    .rst_n       (rst_n),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release)
  );

  initial pixel_clk = 1'b0;
  always #5 pixel_clk = ~pixel_clk;

  always @(posedge pixel_clk) cyc <= cyc + 1;

  task automatic check(input string name, input int actual, input int expected);
    n_total++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge pixel_clk);
  endtask

  task automatic expect_ev(input int at, input int b, input int is_p);
    ev_t e;
    e.cyc = at;
    e.bitn = b;
    e.is_press = is_p;
    exp_q.push_back(e);
  endtask

  // Monitor: every pulse must match the next queued expectation.
  always @(negedge pixel_clk) begin
    if (rst_n) begin
      for (int b = 0; b < NB; b++) begin
        if (btn_press[b] || btn_release[b]) begin
          ev_t e;
          check("pulse_overlap", int'(btn_press[b] & btn_release[b]), 0);
          if (exp_q.size() == 0) begin
            check("unexpected_pulse_bit", b, -1);
          end else begin
            e = exp_q.pop_front();
            check("ev_cycle", cyc, e.cyc);
            check("ev_bit", b, e.bitn);
            check("ev_kind", int'(btn_press[b]), e.is_press);
          end
        end
      end
      if (btn_press[0]) begin
        regime = 1 - regime;
        press0_cnt++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    cyc        = 0;
    n_total    = 0;
    n_pass     = 0;
    regime     = 1;
    press0_cnt = 0;
    rst_n      = 1'b0;
    btn_raw    = '0;
    tick(3);
    check("reset_outputs", int'({btn_level, btn_press, btn_release}), 0);
    rst_n = 1'b1;
    tick(2);

    // Clean press and release on c.
    c = cyc; btn_raw[0] = 1'b1; expect_ev(c + LAT, 0, 1);
    tick(LAT - 1);
    check("clean_level_early", int'(btn_level[0]), 0);
    tick(1);
    check("clean_level", int'(btn_level[0]), 1);
    check("clean_press", int'(btn_press[0]), 1);
    tick(1);
    check("clean_press_gone", int'(btn_press[0]), 0);
    check("clean_level_held", int'(btn_level[0]), 1);
    c = cyc; btn_raw[0] = 1'b0; expect_ev(c + LAT, 0, 0);
    tick(LAT + 1);
    check("clean_released", int'(btn_level[0]), 0);

    // Bounce rejection on u.
    begin
      logic [5:0] pat;
      pat = 6'b011011;
      for (int i = 0; i < 6; i++) begin
        btn_raw[1] = pat[i];
        tick(1);
      end
      btn_raw[1] = 1'b0;
      tick(10);
      check("bounce_level", int'(btn_level[1]), 0);
    end

    // Release glitch on d.
    c = cyc; btn_raw[2] = 1'b1; expect_ev(c + LAT, 2, 1);
    tick(LAT + 1);
    check("glitch_level_up", int'(btn_level[2]), 1);
    btn_raw[2] = 1'b0; tick(2);
    btn_raw[2] = 1'b1; tick(3);
    check("glitch_level_kept", int'(btn_level[2]), 1);
    c = cyc; btn_raw[2] = 1'b0; expect_ev(c + LAT, 2, 0);
    tick(LAT - 1);
    check("glitch_level_before", int'(btn_level[2]), 1);
    tick(2);
    check("glitch_level_down", int'(btn_level[2]), 0);

    // Simultaneous presses on c, d, l with a long hold.
    c = cyc; btn_raw = 5'b10101;
    expect_ev(c + LAT, 0, 1); expect_ev(c + LAT, 2, 1); expect_ev(c + LAT, 4, 1);
    tick(LAT);
    check("simul_press", int'(btn_press), 5'b10101);
    tick(1);
    check("simul_press_gone", int'(btn_press), 0);
    tick(1000);
    check("simul_level_held", int'(btn_level), 5'b10101);
    c = cyc; btn_raw = '0;
    expect_ev(c + LAT, 0, 0); expect_ev(c + LAT, 2, 0); expect_ev(c + LAT, 4, 0);
    tick(LAT + 2);
    check("simul_level_down", int'(btn_level), 0);

    // Async reset while r is mid-debounce and c is held.
    c = cyc; btn_raw[0] = 1'b1; expect_ev(c + LAT, 0, 1);
    tick(LAT + 1);
    btn_raw[3] = 1'b1;
    tick(4);
    btn_raw[0] = 1'b0;
    check("pre_reset_level", int'(btn_level), 5'b00001);
    @(posedge pixel_clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", int'({btn_level, btn_press, btn_release}), 0);
    tick(2);
    c = cyc; rst_n = 1'b1; expect_ev(c + LAT, 3, 1);
    tick(LAT - 1);
    check("post_reset_early", int'(btn_level[3]), 0);
    tick(1);
    check("post_reset_level", int'(btn_level[3]), 1);
    c = cyc; btn_raw[3] = 1'b0; expect_ev(c + LAT, 3, 0);
    tick(LAT + 2);

    // Regime toggling from two separate presses on c.
    regime = 1; press0_cnt = 0;
    c = cyc; btn_raw[0] = 1'b1; expect_ev(c + LAT, 0, 1);
    tick(20);
    check("regime_after_first", regime, 0);
    c = cyc; btn_raw[0] = 1'b0; expect_ev(c + LAT, 0, 0);
    tick(20);
    c = cyc; btn_raw[0] = 1'b1; expect_ev(c + LAT, 0, 1);
    tick(20);
    check("regime_after_second", regime, 1);
    c = cyc; btn_raw[0] = 1'b0; expect_ev(c + LAT, 0, 0);
    tick(LAT + 3);
    check("regime_press_count", press0_cnt, 2);

    check("events_outstanding", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
